// File: rtl/shift_serdes_pkg.sv
// Shared types and helpers for the shift_serdes serial/parallel converter.
//   piso_state_t : serialiser FSM states
//   cnt_w()      : bit-counter width for a given word width
package shift_serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH bit counter used for both the SIPO and PISO word positions.
//   clk, rst : clock, async active-high reset
//   en       : advance one position (wraps to 0 after WIDTH-1)
//   clr      : synchronous return to 0, wins over en
//   count    : current position
//   at_last  : count is at WIDTH-1
module shift_bit_counter
    import shift_serdes_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_last
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign at_last = (count_q == CW'(WIDTH - 1));
    assign count   = count_q;

    // Next position: clear first, otherwise wrap at the last position.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/shift_serdes.sv
// Independent SIPO deserialiser and PISO serialiser with selectable bit order.
//   clk, rst                  : clock, async active-high reset
//   serial_in, sin_valid      : SIPO bit and its qualifier
//   sipo_clear                : drop the partially assembled SIPO word
//   parallel_out, pout_valid  : last completed SIPO word and its 1-cycle pulse
//   par_in, load_valid        : PISO word and load request
//   load_ready                : PISO can take a word this cycle (combinational)
//   serial_out, sout_valid    : PISO bit and its qualifier
//   sout_last                 : marks the final bit of each PISO word
module shift_serdes
    import shift_serdes_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             sin_valid,
    input  logic             sipo_clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic             pout_valid,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int unsigned CW = cnt_w(WIDTH);

    // ------------------------------------------------------------------
    // SIPO path
    // ------------------------------------------------------------------
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             sipo_en;
    logic             sipo_done;
    logic [CW-1:0]    tap_idx;
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] parallel_out_q;
    logic             pout_valid_q;

    // Clear wins over a coincident valid bit, so that bit never counts.
    assign sipo_en   = sin_valid & ~sipo_clear;
    assign sipo_done = sipo_en & cnt_last;

    shift_bit_counter #(.WIDTH(WIDTH)) u_sipo_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (sipo_en),
        .clr     (sipo_clear),
        .count   (cnt),
        .at_last (cnt_last)
    );

    // Word bit that receives the incoming serial bit at position cnt.
    generate
        if (MSB_FIRST) begin : g_sipo_msb
            assign tap_idx = CW'(WIDTH - 1) - cnt;
        end else begin : g_sipo_lsb
            assign tap_idx = cnt;
        end
    endgenerate

    // word_c is the staging word with the current bit dropped in place;
    // on completion it is the full word and staging restarts empty.
    always_comb begin
        word_c          = stage_q;
        word_c[tap_idx] = serial_in;
        stage_d         = stage_q;
        if (sipo_clear || sipo_done) begin
            stage_d = '0;
        end else if (sipo_en) begin
            stage_d = word_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q        <= '0;
            parallel_out_q <= '0;
            pout_valid_q   <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            pout_valid_q <= sipo_done;
            if (sipo_done) begin
                parallel_out_q <= word_c;
            end
        end
    end

    assign parallel_out = parallel_out_q;
    assign pout_valid   = pout_valid_q;

    // ------------------------------------------------------------------
    // PISO path
    // ------------------------------------------------------------------
    piso_state_t      state_q;
    logic [CW-1:0]    bcnt;
    logic             bcnt_last;
    logic             accept;
    logic             piso_en;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_shift;
    logic             sh_tap;
    logic             sout_valid_q;
    logic             sout_last_q;

    // Ready in IDLE, or on the last bit so the next word follows without a gap.
    assign load_ready = (state_q == IDLE) | bcnt_last;
    assign accept     = load_valid & load_ready;
    assign piso_en    = (state_q == SHIFT);

    shift_bit_counter #(.WIDTH(WIDTH)) u_piso_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (piso_en),
        .clr     (accept),
        .count   (bcnt),
        .at_last (bcnt_last)
    );

    // The tap of sh_q is always the bit on the wire; sh_q is zero when idle.
    generate
        if (MSB_FIRST) begin : g_piso_msb
            assign sh_shift = {sh_q[WIDTH-2:0], 1'b0};
            assign sh_tap   = sh_q[WIDTH-1];
        end else begin : g_piso_lsb
            assign sh_shift = {1'b0, sh_q[WIDTH-1:1]};
            assign sh_tap   = sh_q[0];
        end
    endgenerate

    // Serialiser FSM; sout_last is pre-computed one bit ahead (bcnt==WIDTH-2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= SHIFT;
                        sh_q         <= par_in;
                        sout_valid_q <= 1'b1;
                        sout_last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        sh_q        <= par_in;
                        sout_last_q <= 1'b0;
                    end else if (bcnt_last) begin
                        state_q      <= IDLE;
                        sh_q         <= '0;
                        sout_valid_q <= 1'b0;
                        sout_last_q  <= 1'b0;
                    end else begin
                        sh_q        <= sh_shift;
                        sout_last_q <= (bcnt == CW'(WIDTH - 2));
                    end
                end
            endcase
        end
    end

    assign serial_out = sh_tap;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;

endmodule

// File: tb/tb_shift_serdes.sv
// Scoreboard bench for shift_serdes: one MSB-first and one LSB-first instance
// driven with identical stimulus, checked against a queue-based reference model.
module tb_shift_serdes;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin, sin_v, clr, ld_v;
    logic [7:0] par;

    logic [7:0] po_m, po_l;
    logic       pv_m, pv_l, lr_m, lr_l, so_m, so_l, sv_m, sv_l, sl_m, sl_l;

    shift_serdes #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .serial_in(sin), .sin_valid(sin_v), .sipo_clear(clr),
        .parallel_out(po_m), .pout_valid(pv_m), .par_in(par), .load_valid(ld_v),
        .load_ready(lr_m), .serial_out(so_m), .sout_valid(sv_m), .sout_last(sl_m)
    );

    shift_serdes #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .serial_in(sin), .sin_valid(sin_v), .sipo_clear(clr),
        .parallel_out(po_l), .pout_valid(pv_l), .par_in(par), .load_valid(ld_v),
        .load_ready(lr_l), .serial_out(so_l), .sout_valid(sv_l), .sout_last(sl_l)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit         sbits[$];                 // SIPO bits received so far, arrival order
    logic [7:0] exp_w_m[$], exp_w_l[$];   // expected completed words
    bit         exp_b_m[$], exp_b_l[$];   // expected serial bits
    bit         exp_t_m[$], exp_t_l[$];   // expected last flags
    int         p = 0;                    // PISO bits still to show, including current

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [7:0] sipo_word(input bit msb);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (msb) w[7-i] = sbits[i];
            else     w[i]   = sbits[i];
        end
        return w;
    endfunction

    // Called at posedge+1: check ready/valid, apply inputs for the next edge, advance model.
    task automatic step(input bit sv, input bit sb, input bit cl, input bit lv, input logic [7:0] pw);
        bit rdy;
        rdy = (p <= 1);
        chk("load_ready_m", 32'(lr_m), 32'(rdy));
        chk("load_ready_l", 32'(lr_l), 32'(rdy));
        chk("sout_valid_m", 32'(sv_m), 32'(p > 0));
        chk("sout_valid_l", 32'(sv_l), 32'(p > 0));
        sin_v = sv; sin = sb; clr = cl; ld_v = lv; par = pw;
        if (p > 0) p--;
        if (lv && rdy) begin
            for (int i = 0; i < 8; i++) begin
                exp_b_m.push_back(pw[7-i]);
                exp_b_l.push_back(pw[i]);
                exp_t_m.push_back(i == 7);
                exp_t_l.push_back(i == 7);
            end
            p += 8;
        end
        if (cl) begin
            sbits.delete();
        end else if (sv) begin
            sbits.push_back(sb);
            if (sbits.size() == 8) begin
                exp_w_m.push_back(sipo_word(1'b1));
                exp_w_l.push_back(sipo_word(1'b0));
                sbits.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic sipo_byte(input logic [7:0] b, input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            step(1, b[i], 0, 0, 8'h00);
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_po_m"}, 32'(po_m), 0);
        chk({tag, "_po_l"}, 32'(po_l), 0);
        chk({tag, "_pv"},   32'({pv_m, pv_l}), 0);
        chk({tag, "_so"},   32'({so_m, so_l}), 0);
        chk({tag, "_sv"},   32'({sv_m, sv_l}), 0);
        chk({tag, "_sl"},   32'({sl_m, sl_l}), 0);
        chk({tag, "_lr"},   32'({lr_m, lr_l}), 32'h3);
    endtask

    // Assert reset between edges, check outputs immediately, release a cycle later.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        sin_v = 0; sin = 0; clr = 0; ld_v = 0; par = '0;
        #1;
        check_reset_outputs("mid_reset");
        sbits.delete();
        exp_w_m.delete(); exp_w_l.delete();
        exp_b_m.delete(); exp_b_l.delete();
        exp_t_m.delete(); exp_t_l.delete();
        p = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pop and compare whenever a DUT presents an output.
    always @(negedge clk) begin
        if (!rst) begin
            if (pv_m) begin
                if (exp_w_m.size() == 0) flag("unexpected pout_valid_m");
                else chk("parallel_out_m", 32'(po_m), 32'(exp_w_m.pop_front()));
            end
            if (pv_l) begin
                if (exp_w_l.size() == 0) flag("unexpected pout_valid_l");
                else chk("parallel_out_l", 32'(po_l), 32'(exp_w_l.pop_front()));
            end
            if (sv_m) begin
                if (exp_b_m.size() == 0) flag("unexpected sout_valid_m");
                else begin
                    chk("serial_out_m", 32'(so_m), 32'(exp_b_m.pop_front()));
                    chk("sout_last_m",  32'(sl_m), 32'(exp_t_m.pop_front()));
                end
            end else begin
                chk("idle_out_m", 32'({so_m, sl_m}), 0);
            end
            if (sv_l) begin
                if (exp_b_l.size() == 0) flag("unexpected sout_valid_l");
                else begin
                    chk("serial_out_l", 32'(so_l), 32'(exp_b_l.pop_front()));
                    chk("sout_last_l",  32'(sl_l), 32'(exp_t_l.pop_front()));
                end
            end else begin
                chk("idle_out_l", 32'({so_l, sl_l}), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        sin = 0; sin_v = 0; clr = 0; ld_v = 0; par = '0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: SIPO MSB-first, consecutive bits
        sipo_byte(8'hB2, 0);
        idle(2);
        chk("t1_word_m", 32'(po_m), 32'h0000_00B2);
        chk("t1_word_l", 32'(po_l), 32'h0000_004D);

        // Test 2: gaps, then a partial word that is cleared, then B2 again
        sipo_byte(8'hB2, 3);
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 8'h00);   // clear with a coincident valid bit
        idle(2);
        sipo_byte(8'hB2, 2);
        idle(2);
        chk("t2_word_m", 32'(po_m), 32'h0000_00B2);

        // Test 3: PISO single word
        step(0, 0, 0, 1, 8'hA5);
        idle(9);

        // Test 4: back-to-back words chained on the last-bit edge
        step(0, 0, 0, 1, 8'hA5);
        idle(7);
        step(0, 0, 0, 1, 8'h3C);
        idle(9);

        // Test 5: bit order with concurrent SIPO and PISO traffic
        for (int i = 0; i < 8; i++) step(1, (i == 0), 0, (i == 0), 8'h01);
        idle(3);
        chk("t5_word_l", 32'(po_l), 32'h0000_0001);
        chk("t5_word_m", 32'(po_m), 32'h0000_0080);

        // Test 6: reset in the middle of both paths, then a clean replay
        step(1, 1, 0, 1, 8'hA5);
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        mid_reset();
        sipo_byte(8'hB2, 0);
        step(0, 0, 0, 1, 8'hA5);
        idle(9);
        chk("t6_word_m", 32'(po_m), 32'h0000_00B2);

        // Random traffic with one reset in the middle
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) mid_reset();
            step(bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                 ($urandom_range(31, 0) == 0), ($urandom_range(2, 0) == 0),
                 8'($urandom_range(255, 0)));
        end
        idle(12);

        chk("drain_words",  32'(exp_w_m.size() + exp_w_l.size()), 0);
        chk("drain_bits",   32'(exp_b_m.size() + exp_b_l.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
